// File: rtl/dmem_port_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_port_sequencer
//  Purpose  : Arbitrates the single data-memory port between the MEM stage
//             and the loader/debug port. Sub-word stores become an aligned
//             read-modify-write pair. The memory only ever sees whole-word
//             transfers. The MEM stage is stalled while its access is open.
//  Revision : 1.0  initial release
// ============================================================================
module dmem_port_sequencer #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        m_req,
  input  logic        m_we,
  input  logic [1:0]  m_size,
  input  logic [31:0] m_addr,
  input  logic [31:0] m_wdata,
  output logic        m_done,
  output logic        m_err,
  output logic        m_stall,
  input  logic        l_req,
  input  logic        l_we,
  input  logic [1:0]  l_size,
  input  logic [31:0] l_addr,
  input  logic [31:0] l_wdata,
  output logic        l_done,
  output logic        l_err,
  output logic [31:0] rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  localparam int         CW      = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] C_LIMIT = CW'(STARVE_LIMIT);
  localparam logic [1:0] C_SZ_WORD = 2'd0;
  localparam logic [1:0] C_SZ_HALF = 2'd2;
  localparam logic [1:0] C_SZ_ILL  = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RD    = 3'd1,
    S_MERGE = 3'd2,
    S_WR    = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t         state_q;
  logic           own_l_q;
  logic           we_q;
  logic [1:0]     size_q;
  logic [1:0]     off_q;
  logic [15:0]    wdata_q;
  logic [31:0]    rd_word_q;
  logic [CW-1:0]  starve_q;
  logic           mem_req_q, mem_we_q;
  logic [31:0]    mem_addr_q, mem_wdata_q, rdata_q;
  logic           m_done_q, l_done_q, m_err_q, l_err_q;

  logic           pick_m, pick_l, pick_any;
  logic           sel_we;
  logic [1:0]     sel_size;
  logic [31:0]    sel_addr, sel_wdata;
  logic           sel_bad;
  logic [31:0]    wdata_merge_d;

  // Grant: MEM has priority unless the loader has been starved long enough.
  always_comb begin
    pick_m    = m_req & ~((starve_q == C_LIMIT) & l_req);
    pick_l    = l_req & ~pick_m;
    pick_any  = pick_m | pick_l;
    sel_we    = pick_m ? m_we    : l_we;
    sel_size  = pick_m ? m_size  : l_size;
    sel_addr  = pick_m ? m_addr  : l_addr;
    sel_wdata = pick_m ? m_wdata : l_wdata;
    sel_bad   = (sel_size == C_SZ_ILL) | ((sel_size == C_SZ_HALF) & sel_addr[0]);
  end

  // Replace the addressed big-endian lane(s) of the read word with store data.
  always_comb begin
    wdata_merge_d = rd_word_q;
    if (size_q == C_SZ_HALF) begin
      if (off_q[1]) wdata_merge_d[15:0]  = wdata_q;
      else          wdata_merge_d[31:16] = wdata_q;
    end else begin
      case (off_q)
        2'd0:    wdata_merge_d[31:24] = wdata_q[7:0];
        2'd1:    wdata_merge_d[23:16] = wdata_q[7:0];
        2'd2:    wdata_merge_d[15:8]  = wdata_q[7:0];
        default: wdata_merge_d[7:0]   = wdata_q[7:0];
      endcase
    end
  end

  // Transaction sequencer with registered memory-side and completion outputs.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q     <= S_IDLE;
      own_l_q     <= 1'b0;
      we_q        <= 1'b0;
      size_q      <= 2'd0;
      off_q       <= 2'd0;
      wdata_q     <= 16'd0;
      rd_word_q   <= 32'd0;
      starve_q    <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 32'd0;
      rdata_q     <= 32'd0;
      m_done_q    <= 1'b0;
      l_done_q    <= 1'b0;
      m_err_q     <= 1'b0;
      l_err_q     <= 1'b0;
    end else begin
      m_done_q <= 1'b0;
      l_done_q <= 1'b0;
      m_err_q  <= 1'b0;
      l_err_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (pick_any) begin
            own_l_q    <= pick_l;
            we_q       <= sel_we;
            size_q     <= sel_size;
            off_q      <= sel_addr[1:0];
            wdata_q    <= sel_wdata[15:0];
            mem_addr_q <= {sel_addr[31:2], 2'b00};
            if (sel_bad) begin
              // Rejected without touching memory.
              m_done_q <= pick_m;
              l_done_q <= pick_l;
              m_err_q  <= pick_m;
              l_err_q  <= pick_l;
              state_q  <= S_DONE;
            end else if (sel_we && sel_size == C_SZ_WORD) begin
              mem_wdata_q <= sel_wdata;
              mem_req_q   <= 1'b1;
              mem_we_q    <= 1'b1;
              state_q     <= S_WR;
            end else begin
              mem_req_q <= 1'b1;
              mem_we_q  <= 1'b0;
              state_q   <= S_RD;
            end
          end
        end
        S_RD: begin
          if (mem_ack) begin
            rd_word_q <= mem_rdata;
            mem_req_q <= 1'b0;
            if (we_q) begin
              state_q <= S_MERGE;
            end else begin
              rdata_q  <= mem_rdata;
              m_done_q <= ~own_l_q;
              l_done_q <= own_l_q;
              state_q  <= S_DONE;
            end
          end
        end
        S_MERGE: begin
          mem_wdata_q <= wdata_merge_d;
          mem_req_q   <= 1'b1;
          mem_we_q    <= 1'b1;
          state_q     <= S_WR;
        end
        S_WR: begin
          if (mem_ack) begin
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            m_done_q  <= ~own_l_q;
            l_done_q  <= own_l_q;
            state_q   <= S_DONE;
          end
        end
        S_DONE: begin
          if (!own_l_q && l_req)
            starve_q <= (starve_q == C_LIMIT) ? starve_q : starve_q + CW'(1);
          else
            starve_q <= '0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign m_done    = m_done_q;
  assign l_done    = l_done_q;
  assign m_err     = m_err_q;
  assign l_err     = l_err_q;
  assign rdata     = rdata_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign m_stall   = m_req & ~m_done_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_port_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dmem_port_sequencer
//  Purpose  : Directed self-checking bench for dmem_port_sequencer.
//  Revision : 1.0  initial release
// ============================================================================
module tb_dmem_port_sequencer;

  logic        CLK, RESET;
  logic        m_req, m_we, l_req, l_we;
  logic [1:0]  m_size, l_size;
  logic [31:0] m_addr, m_wdata, l_addr, l_wdata;
  logic        m_done, m_err, m_stall, l_done, l_err;
  logic [31:0] rdata;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int tests = 0;
  int fails = 0;

  // Memory model state
  logic [31:0] mem [logic [31:0]];
  int          ack_delay = 0;
  int          wcnt = 0;
  logic        in_req = 0;
  logic [31:0] req_addr, req_wdata;
  int          n_reqs = 0;
  int          n_writes = 0;
  logic        unstable = 0;
  int          m_done_cnt = 0;
  int          l_done_cnt = 0;

  dmem_port_sequencer #(.STARVE_LIMIT(4)) dut (
    .CLK(CLK), .RESET(RESET),
    .m_req(m_req), .m_we(m_we), .m_size(m_size), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_done(m_done), .m_err(m_err), .m_stall(m_stall),
    .l_req(l_req), .l_we(l_we), .l_size(l_size), .l_addr(l_addr), .l_wdata(l_wdata),
    .l_done(l_done), .l_err(l_err), .rdata(rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  initial begin
    CLK = 0;
    forever #5 CLK = ~CLK;
  end

  // Memory with programmable ack latency; responds and records at negedge.
  always @(negedge CLK) begin
    if (m_done === 1'b1) m_done_cnt++;
    if (l_done === 1'b1) l_done_cnt++;
    if (mem_req === 1'b1) begin
      if (!in_req) begin
        in_req = 1; req_addr = mem_addr; req_wdata = mem_wdata; n_reqs++;
      end else if (mem_addr !== req_addr || mem_wdata !== req_wdata) begin
        unstable = 1;
      end
      if (wcnt == ack_delay) begin
        mem_ack   = 1;
        mem_rdata = mem.exists(mem_addr) ? mem[mem_addr] : 32'd0;
        if (mem_we) begin
          mem[mem_addr] = mem_wdata;
          n_writes++;
        end
        wcnt = 0; in_req = 0;
      end else begin
        mem_ack = 0; mem_rdata = 32'hDEAD_BEEF; wcnt++;
      end
    end else begin
      mem_ack = 0; mem_rdata = 32'hDEAD_BEEF; wcnt = 0; in_req = 0;
    end
  end

  function automatic logic [31:0] rd_mem(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 32'd0;
  endfunction

  // Runs one MEM-stage transaction; lat is the cycle m_done is seen (0 = timeout).
  task automatic m_txn(input logic we, input logic [1:0] sz, input logic [31:0] a,
                       input logic [31:0] wd, output int lat, output logic er,
                       output logic stall_ok);
    @(posedge CLK); #1;
    m_req = 1; m_we = we; m_size = sz; m_addr = a; m_wdata = wd;
    lat = 0; er = 0; stall_ok = 1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge CLK);
      if (m_done === 1'b1) begin
        lat = n; er = m_err;
        if (m_stall !== 1'b0) stall_ok = 0;
        break;
      end
      if (m_stall !== 1'b1) stall_ok = 0;
      @(posedge CLK); #1;
    end
    @(posedge CLK); #1;
    m_req = 0;
  endtask

  task automatic test_reset;
    RESET = 0; m_req = 1; #3;
    tests++;
    if ({mem_req, mem_we, m_done, l_done, m_err, l_err} !== 6'b0) begin
      fails++; $display("FAIL reset_ctrl: got %b want 000000", {mem_req, mem_we, m_done, l_done, m_err, l_err});
    end
    tests++;
    if ({mem_addr, mem_wdata, rdata} !== 96'd0) begin
      fails++; $display("FAIL reset_data: got %h %h %h want zeros", mem_addr, mem_wdata, rdata);
    end
    tests++;
    if (m_stall !== 1'b1) begin fails++; $display("FAIL reset_stall_hi: got %b want 1", m_stall); end
    m_req = 0; #1;
    tests++;
    if (m_stall !== 1'b0) begin fails++; $display("FAIL reset_stall_lo: got %b want 0", m_stall); end
    @(negedge CLK); RESET = 1;
  endtask

  task automatic test_load;
    int lat; logic er, sok; int nr, nw, ld;
    nr = n_reqs; nw = n_writes; ld = l_done_cnt;
    m_txn(0, 2'd0, 32'h103, 32'h0, lat, er, sok);
    tests++; if (lat != 3) begin fails++; $display("FAIL load_lat: got %0d want 3", lat); end
    tests++; if (rdata !== 32'hA1B2C3D4) begin fails++; $display("FAIL load_rdata: got %h want a1b2c3d4", rdata); end
    tests++; if (req_addr !== 32'h100) begin fails++; $display("FAIL load_addr: got %h want 00000100", req_addr); end
    tests++; if (!sok) begin fails++; $display("FAIL load_stall: got bad stall want high until done"); end
    tests++;
    if (er !== 1'b0 || n_reqs - nr != 1 || n_writes != nw || l_done_cnt != ld) begin
      fails++; $display("FAIL load_side: err %b reqs %0d writes %0d ldone %0d want 0 1 0 0", er, n_reqs - nr, n_writes - nw, l_done_cnt - ld);
    end
  endtask

  task automatic test_subword;
    int lat; logic er, sok; int nr;
    nr = n_reqs;
    m_txn(1, 2'd1, 32'h201, 32'h55, lat, er, sok);
    tests++; if (lat != 5) begin fails++; $display("FAIL sb_lat: got %0d want 5", lat); end
    tests++; if (rd_mem(32'h200) !== 32'h11553344) begin fails++; $display("FAIL sb_data: got %h want 11553344", rd_mem(32'h200)); end
    tests++; if (n_reqs - nr != 2 || rdata !== 32'hA1B2C3D4) begin
      fails++; $display("FAIL sb_side: reqs %0d rdata %h want 2 a1b2c3d4", n_reqs - nr, rdata);
    end
    m_txn(1, 2'd1, 32'h203, 32'h1AA, lat, er, sok);
    tests++; if (rd_mem(32'h200) !== 32'h115533AA) begin fails++; $display("FAIL sb3_data: got %h want 115533aa", rd_mem(32'h200)); end
    m_txn(1, 2'd2, 32'h302, 32'hBEEF, lat, er, sok);
    tests++; if (lat != 5 || rd_mem(32'h300) !== 32'h1122BEEF) begin
      fails++; $display("FAIL sh2: lat %0d data %h want 5 1122beef", lat, rd_mem(32'h300));
    end
    m_txn(1, 2'd2, 32'h300, 32'h7788, lat, er, sok);
    tests++; if (rd_mem(32'h300) !== 32'h7788BEEF) begin fails++; $display("FAIL sh0: got %h want 7788beef", rd_mem(32'h300)); end
  endtask

  task automatic test_errors;
    int lat; logic er, sok; int nr;
    nr = n_reqs;
    m_txn(1, 2'd2, 32'h301, 32'h1234, lat, er, sok);
    tests++; if (lat != 2 || er !== 1'b1) begin fails++; $display("FAIL sh1_err: lat %0d err %b want 2 1", lat, er); end
    m_txn(0, 2'd3, 32'h100, 32'h0, lat, er, sok);
    tests++; if (lat != 2 || er !== 1'b1) begin fails++; $display("FAIL ill_err: lat %0d err %b want 2 1", lat, er); end
    tests++; if (n_reqs != nr) begin fails++; $display("FAIL err_nomem: reqs %0d want 0", n_reqs - nr); end
    m_txn(0, 2'd2, 32'h302, 32'h0, lat, er, sok);
    tests++; if (lat != 3 || er !== 1'b0 || rdata !== 32'h7788BEEF) begin
      fails++; $display("FAIL lh_ok: lat %0d err %b rdata %h want 3 0 7788beef", lat, er, rdata);
    end
  endtask

  task automatic test_wait_states;
    int lat; logic er, sok;
    unstable = 0; ack_delay = 3;
    m_txn(1, 2'd0, 32'h502, 32'h12345678, lat, er, sok);
    tests++; if (lat != 6) begin fails++; $display("FAIL wait_lat: got %0d want 6", lat); end
    tests++; if (unstable !== 1'b0 || rd_mem(32'h500) !== 32'h12345678) begin
      fails++; $display("FAIL wait_stable: unstable %b data %h want 0 12345678", unstable, rd_mem(32'h500));
    end
    ack_delay = 2;
    m_txn(0, 2'd0, 32'h500, 32'h0, lat, er, sok);
    tests++; if (lat != 5 || rdata !== 32'h12345678) begin fails++; $display("FAIL wait_load: lat %0d rdata %h want 5 12345678", lat, rdata); end
    ack_delay = 0;
  endtask

  task automatic test_loader;
    int md; int lat;
    md = m_done_cnt; lat = 0;
    @(posedge CLK); #1;
    l_req = 1; l_we = 1; l_size = 2'd0; l_addr = 32'h600; l_wdata = 32'hCAFEF00D;
    for (int n = 1; n <= 40; n++) begin
      @(negedge CLK);
      if (l_done === 1'b1) begin lat = n; break; end
      @(posedge CLK); #1;
    end
    @(posedge CLK); #1; l_req = 0;
    tests++; if (lat != 3 || rd_mem(32'h600) !== 32'hCAFEF00D || m_done_cnt != md) begin
      fails++; $display("FAIL loader_wr: lat %0d data %h mdone %0d want 3 cafef00d 0", lat, rd_mem(32'h600), m_done_cnt - md);
    end
  endtask

  task automatic test_back_to_back_starve;
    logic [5:0] rec; int k; logic ldrop; logic [31:0] l_rd;
    rec = '0; k = 0; ldrop = 0; l_rd = '0;
    @(posedge CLK); #1;
    m_req = 1; m_we = 0; m_size = 2'd0; m_addr = 32'h100;
    l_req = 1; l_we = 0; l_size = 2'd0; l_addr = 32'h600;
    for (int n = 0; n < 200 && k < 6; n++) begin
      @(negedge CLK);
      if (m_done === 1'b1) begin rec[k] = 1'b0; k++; end
      if (l_done === 1'b1) begin rec[k] = 1'b1; k++; ldrop = 1; l_rd = rdata; end
      @(posedge CLK); #1;
      if (ldrop) l_req = 0;
    end
    m_req = 0; l_req = 0;
    tests++; if (k != 6 || rec !== 6'b010000) begin fails++; $display("FAIL starve_order: got %0d dones %b want 6 010000", k, rec); end
    tests++; if (l_rd !== 32'hCAFEF00D) begin fails++; $display("FAIL starve_lrdata: got %h want cafef00d", l_rd); end
    repeat (3) @(posedge CLK);
  endtask

  task automatic test_reset_mid;
    int lat; logic er, sok; logic seen;
    seen = 0; ack_delay = 5;
    @(posedge CLK); #1;
    m_req = 1; m_we = 1; m_size = 2'd1; m_addr = 32'h202; m_wdata = 32'h77;
    for (int n = 0; n < 30; n++) begin
      @(negedge CLK);
      if (mem_req === 1'b1 && mem_we === 1'b1) begin seen = 1; break; end
    end
    tests++; if (!seen) begin fails++; $display("FAIL rmid_wr: got no write phase want write phase"); end
    #2 RESET = 0; m_req = 0; #1;
    tests++;
    if ({mem_req, mem_we, m_done, m_err, l_done, l_err} !== 6'b0 || {mem_addr, mem_wdata, rdata} !== 96'd0) begin
      fails++; $display("FAIL rmid_clear: ctrl %b data %h %h %h want zeros", {mem_req, mem_we, m_done, m_err, l_done, l_err}, mem_addr, mem_wdata, rdata);
    end
    @(negedge CLK); @(negedge CLK); RESET = 1; ack_delay = 0;
    m_txn(0, 2'd0, 32'h100, 32'h0, lat, er, sok);
    tests++; if (lat != 3 || rdata !== 32'hA1B2C3D4) begin fails++; $display("FAIL rmid_reload: lat %0d rdata %h want 3 a1b2c3d4", lat, rdata); end
  endtask

  initial begin
    RESET = 0;
    m_req = 0; m_we = 0; m_size = 0; m_addr = 0; m_wdata = 0;
    l_req = 0; l_we = 0; l_size = 0; l_addr = 0; l_wdata = 0;
    mem_ack = 0; mem_rdata = 0;
    mem[32'h100] = 32'hA1B2C3D4;
    mem[32'h200] = 32'h11223344;
    mem[32'h300] = 32'h11223344;
    test_reset;
    test_load;
    test_subword;
    test_errors;
    test_wait_states;
    test_loader;
    test_back_to_back_starve;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
